// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one synchronous-read memory port between the 6502 CPU bus and a
// DMA/debug burst engine. The DMA engine runs bursts of up to 256 beats from a
// base address. While the CPU is waiting, the DMA engine may take at most BURST
// consecutive beats before the CPU gets one slot. The CPU gets every slot the
// DMA engine does not use.
//
// Ports
//   ph1, reset            clock (rising edge) and synchronous active-high reset
//   cpu_req/we/addr/wdata CPU access request; cpu_rdy grants it this cycle
//   cpu_rdata/rvalid      CPU read data, valid the cycle after a granted read
//   dma_start/we/base/len burst start pulse and burst parameters (len 0 = 256)
//   dma_wdata/wvalid      write beat data; dma_wready marks a consumed beat
//   dma_rdata/rvalid      read beat data, valid the cycle after the beat
//   dma_busy, dma_done    burst in progress; one-cycle completion pulse
//   mem_addr/we/wdata     memory port; mem_rdata is valid one cycle after addr
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int BURST  = 4
) (
   input  logic              ph1,
   input  logic              reset,
   // CPU side
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rdy,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   // DMA side
   input  logic              dma_start,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_base,
   input  logic [7:0]        dma_len,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_wvalid,
   output logic              dma_wready,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              dma_busy,
   output logic              dma_done,
   // Memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               RUN_W   = (BURST < 1) ? 1 : $clog2(BURST + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST);

   logic              active_q, active_d;
   logic              dir_q,    dir_d;
   logic [ADDR_W-1:0] ptr_q,    ptr_d;
   logic [8:0]        remain_q, remain_d;
   logic [RUN_W-1:0]  run_q,    run_d;
   logic              cpu_rd_q, cpu_rd_d;
   logic              dma_rd_q, dma_rd_d;
   logic              last_q,   last_d;

   logic              dma_elig;
   logic              cpu_grant;

   // A DMA beat goes out unless the CPU is waiting and the DMA engine has
   // already used up its run, or a write burst has no data to offer.
   assign dma_elig  = active_q && ((run_q < RUN_MAX) || !cpu_req) && (!dir_q || dma_wvalid);
   assign cpu_grant = !dma_elig && cpu_req;

   // Idle slots still present the CPU address/data so the port only toggles
   // when the CPU changes its request.
   assign mem_addr   = dma_elig ? ptr_q     : cpu_addr;
   assign mem_wdata  = dma_elig ? dma_wdata : cpu_wdata;
   assign mem_we     = dma_elig ? dir_q     : (cpu_grant && cpu_we);

   assign cpu_rdy    = cpu_grant;
   assign dma_wready = dma_elig && dir_q;

   assign cpu_rdata  = mem_rdata;
   assign dma_rdata  = mem_rdata;
   assign cpu_rvalid = cpu_rd_q;
   assign dma_rvalid = dma_rd_q;
   assign dma_busy   = active_q;
   assign dma_done   = last_q;

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one
      // unassigned; an unassigned path would infer a latch.
      active_d = active_q;
      dir_d    = dir_q;
      ptr_d    = ptr_q;
      remain_d = remain_q;
      run_d    = run_q;
      cpu_rd_d = cpu_grant && !cpu_we;
      dma_rd_d = dma_elig && !dir_q;
      last_d   = dma_elig && (remain_q == 9'd1);

      if (dma_elig) begin
         ptr_d    = ptr_q + ADDR_W'(1);
         remain_d = remain_q - 9'd1;
         run_d    = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
         if (remain_q == 9'd1) begin
            active_d = 1'b0;
         end
      end else if (cpu_req) begin
         run_d = '0;
      end

      // A start only lands while idle, so it never overlaps a beat above.
      if (dma_start && !active_q) begin
         active_d = 1'b1;
         dir_d    = dma_we;
         ptr_d    = dma_base;
         remain_d = (dma_len == 8'd0) ? 9'd256 : {1'b0, dma_len};
         run_d    = '0;
      end
   end

   always_ff @(posedge ph1) begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      if (reset) begin
         active_q <= 1'b0;
         dir_q    <= 1'b0;
         ptr_q    <= '0;
         remain_q <= '0;
         run_q    <= '0;
         cpu_rd_q <= 1'b0;
         dma_rd_q <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         dir_q    <= dir_d;
         ptr_q    <= ptr_d;
         remain_q <= remain_d;
         run_q    <= run_d;
         cpu_rd_q <= cpu_rd_d;
         dma_rd_q <= dma_rd_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Drives the arbiter against a synchronous-read RAM. A transaction-level model
// (integer counters and a shadow memory) predicts every slot, address, write,
// read return and burst status; each scenario task compares what it cares about.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int BURST = 4;

   logic        ph1 = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_rdy;
   logic [7:0]  cpu_rdata;
   logic        cpu_rvalid;
   logic        dma_start, dma_we;
   logic [15:0] dma_base;
   logic [7:0]  dma_len;
   logic [7:0]  dma_wdata;
   logic        dma_wvalid;
   logic        dma_wready;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid, dma_busy, dma_done;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 ph1 = ~ph1;

   mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST(BURST)) dut (
      .ph1(ph1), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
      .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous-read RAM behind the arbiter.
   logic [7:0] ram     [0:65535];
   logic [7:0] exp_mem [0:65535];

   always @(posedge ph1) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // ---------------- reference model ----------------
   int         m_active, m_dir, m_ptr, m_left, m_streak;
   bit         m_cpu_rv, m_dma_rv, m_done;
   logic [7:0] m_rdata;

   int         e_slot;      // 0 idle, 1 DMA beat, 2 CPU access
   bit         e_cpu_rdy, e_wready, e_mem_we, e_busy, e_done, e_cpu_rv, e_dma_rv;
   logic [15:0] e_addr;
   logic [7:0]  e_wdata, e_rdata;

   logic        o_cpu_rdy, o_wready, o_mem_we, o_busy, o_done, o_cpu_rv, o_dma_rv;
   logic [15:0] o_addr;
   logic [7:0]  o_wdata, o_cpu_rdata, o_dma_rdata;

   task automatic model_eval();
      bit dma_turn;
      e_busy   = (m_active != 0);
      e_done   = m_done;
      e_cpu_rv = m_cpu_rv;
      e_dma_rv = m_dma_rv;
      e_rdata  = m_rdata;
      dma_turn = (m_active != 0) && (m_streak < BURST || !cpu_req) && (m_dir == 0 || dma_wvalid);
      if (dma_turn) begin
         e_slot = 1; e_addr = 16'(m_ptr); e_mem_we = (m_dir != 0); e_wdata = dma_wdata;
         e_cpu_rdy = 0; e_wready = (m_dir != 0);
      end else if (cpu_req) begin
         e_slot = 2; e_addr = cpu_addr; e_mem_we = cpu_we; e_wdata = cpu_wdata;
         e_cpu_rdy = 1; e_wready = 0;
      end else begin
         e_slot = 0; e_addr = cpu_addr; e_mem_we = 0; e_wdata = cpu_wdata;
         e_cpu_rdy = 0; e_wready = 0;
      end
   endtask

   task automatic model_update();
      logic [7:0] rd;
      bit was_active;
      was_active = (m_active != 0);
      rd = exp_mem[e_addr];
      if (e_mem_we) exp_mem[e_addr] = e_wdata;
      if (reset) begin
         m_active = 0; m_dir = 0; m_ptr = 0; m_left = 0; m_streak = 0;
         m_cpu_rv = 0; m_dma_rv = 0; m_done = 0;
      end else begin
         m_cpu_rv = (e_slot == 2) && !cpu_we;
         m_dma_rv = (e_slot == 1) && (m_dir == 0);
         m_rdata  = rd;
         m_done   = (e_slot == 1) && (m_left == 1);
         if (e_slot == 1) begin
            m_ptr = (m_ptr + 1) % 65536;
            m_left--;
            if (m_left == 0) m_active = 0;
            if (m_streak < BURST) m_streak++;
         end else if (e_slot == 2) begin
            m_streak = 0;
         end
         if (dma_start && !was_active) begin
            m_active = 1; m_dir = dma_we; m_ptr = dma_base;
            m_left = (dma_len == 0) ? 256 : dma_len; m_streak = 0;
         end
      end
   endtask

   // One clock: sample mid-cycle, advance the model, return just after the edge.
   task automatic tick();
      @(negedge ph1);
      model_eval();
      o_cpu_rdy = cpu_rdy;   o_wready = dma_wready; o_mem_we = mem_we;
      o_busy = dma_busy;     o_done = dma_done;     o_cpu_rv = cpu_rvalid;
      o_dma_rv = dma_rvalid; o_addr = mem_addr;     o_wdata = mem_wdata;
      o_cpu_rdata = cpu_rdata; o_dma_rdata = dma_rdata;
      model_update();
      @(posedge ph1);
      #1;
   endtask

   task automatic start_burst(input bit we, input logic [15:0] base, input logic [7:0] len);
      dma_start = 1; dma_we = we; dma_base = base; dma_len = len;
      tick();
      dma_start = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; tick(); tick();
      reset = 0; cpu_addr = 16'hABCD;
      tick();
      n_assert++; if (o_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_assert++; if (o_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
      n_assert++; if (o_cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rdy: got %b want 0", o_cpu_rdy); end
      n_assert++; if (o_mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", o_mem_we); end
      n_assert++; if (o_wready !== 1'b0)  begin n_fail++; $display("FAIL reset_wready: got %b want 0", o_wready); end
      n_assert++; if (o_cpu_rv !== 1'b0 || o_dma_rv !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got cpu %b dma %b want 0 0", o_cpu_rv, o_dma_rv); end
      n_assert++; if (o_addr !== 16'hABCD) begin n_fail++; $display("FAIL reset_mem_addr: got %h want abcd", o_addr); end
   endtask

   task automatic test_uncontended_write();
      int k = 0;
      cpu_req = 0; dma_wvalid = 1;
      start_burst(1'b1, 16'h0040, 8'd3);
      for (int i = 1; i <= 4; i++) begin
         dma_wdata = 8'h33 + 8'(k);
         tick();
         if (o_wready) k++;
         n_assert++; if (o_cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL uw_cpu_rdy c%0d: got %b want 0", i, o_cpu_rdy); end
         n_assert++; if (o_done !== (i == 4)) begin n_fail++; $display("FAIL uw_done c%0d: got %b want %b", i, o_done, i == 4); end
      end
      dma_wvalid = 0;
      n_assert++; if (k != 3) begin n_fail++; $display("FAIL uw_beats: got %0d want 3", k); end
      n_assert++; if ({ram[16'h40], ram[16'h41], ram[16'h42]} !== 24'h333435)
         begin n_fail++; $display("FAIL uw_ram: got %h%h%h want 333435", ram[16'h40], ram[16'h41], ram[16'h42]); end
   endtask

   task automatic test_contended_read();
      string exp_pat = "DDDDCDDDDCDD";
      bit prev_c;
      int n_rv = 0, n_done = 0;
      byte slot;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'hF000;
      start_burst(1'b0, 16'h0040, 8'd10);
      prev_c = o_cpu_rdy;
      for (int i = 0; i < 13; i++) begin
         tick();
         slot = o_cpu_rdy ? "C" : "D";
         if (i < 12) begin
            n_assert++; if (slot != exp_pat[i]) begin n_fail++; $display("FAIL cr_slot %0d: got %s want %s", i, slot, exp_pat[i]); end
         end
         n_assert++; if (o_cpu_rv !== prev_c) begin n_fail++; $display("FAIL cr_cpu_rvalid %0d: got %b want %b", i, o_cpu_rv, prev_c); end
         if (o_dma_rv === 1'b1) begin
            n_rv++;
            n_assert++; if (o_dma_rdata !== e_rdata) begin n_fail++; $display("FAIL cr_rdata beat %0d: got %h want %h", n_rv, o_dma_rdata, e_rdata); end
         end
         if (o_done === 1'b1) begin
            n_done++;
            n_assert++; if (!(o_dma_rv === 1'b1 && n_rv == 10)) begin n_fail++; $display("FAIL cr_done_align: rvalid %b count %0d want 1 10", o_dma_rv, n_rv); end
         end
         prev_c = o_cpu_rdy;
      end
      n_assert++; if (n_rv != 10)  begin n_fail++; $display("FAIL cr_rvalid_count: got %0d want 10", n_rv); end
      n_assert++; if (n_done != 1) begin n_fail++; $display("FAIL cr_done_count: got %0d want 1", n_done); end
      cpu_req = 0;
   endtask

   task automatic test_write_stall();
      cpu_req = 0; dma_wvalid = 0;
      start_burst(1'b1, 16'h0100, 8'd2);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_assert++; if (o_mem_we !== 1'b0)   begin n_fail++; $display("FAIL ws_mem_we %0d: got %b want 0", i, o_mem_we); end
         n_assert++; if (o_cpu_rdy !== 1'b1)  begin n_fail++; $display("FAIL ws_cpu_rdy %0d: got %b want 1", i, o_cpu_rdy); end
         n_assert++; if (o_addr !== 16'h3000) begin n_fail++; $display("FAIL ws_addr %0d: got %h want 3000", i, o_addr); end
      end
      cpu_req = 0; dma_wvalid = 1; dma_wdata = 8'h5A;
      tick();
      n_assert++; if (o_addr !== 16'h0100 || o_mem_we !== 1'b1) begin n_fail++; $display("FAIL ws_beat0: got addr %h we %b want 0100 1", o_addr, o_mem_we); end
      dma_wdata = 8'h5B;
      tick();
      n_assert++; if (o_addr !== 16'h0101 || o_wready !== 1'b1) begin n_fail++; $display("FAIL ws_beat1: got addr %h wready %b want 0101 1", o_addr, o_wready); end
      dma_wvalid = 0;
      tick();
      n_assert++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL ws_done: got done %b busy %b want 1 0", o_done, o_busy); end
      n_assert++; if ({ram[16'h100], ram[16'h101]} !== 16'h5A5B) begin n_fail++; $display("FAIL ws_ram: got %h%h want 5a5b", ram[16'h100], ram[16'h101]); end
   endtask

   task automatic test_wrap_and_len0();
      int n_rv = 0;
      bit seen = 0;
      cpu_req = 0;
      start_burst(1'b0, 16'hFFFE, 8'd2);
      tick(); n_assert++; if (o_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_a0: got %h want fffe", o_addr); end
      tick(); n_assert++; if (o_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_a1: got %h want ffff", o_addr); end
      tick();
      dma_wvalid = 1;
      start_burst(1'b1, 16'hFFFF, 8'd2);
      dma_wdata = 8'h77; tick(); n_assert++; if (o_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_b0: got %h want ffff", o_addr); end
      dma_wdata = 8'h78; tick(); n_assert++; if (o_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_b1: got %h want 0000", o_addr); end
      dma_wvalid = 0;
      tick();
      n_assert++; if (ram[16'h0000] !== 8'h78) begin n_fail++; $display("FAIL wrap_ram0: got %h want 78", ram[16'h0000]); end
      start_burst(1'b0, 16'h1234, 8'd0);
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         if (o_dma_rv === 1'b1) n_rv++;
         if (o_done === 1'b1) seen = 1;
      end
      n_assert++; if (!seen) begin n_fail++; $display("FAIL len0_timeout: no dma_done within 300 cycles, want done"); end
      n_assert++; if (n_rv != 256) begin n_fail++; $display("FAIL len0_beats: got %0d want 256", n_rv); end
      n_assert++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", o_busy); end
   endtask

   task automatic test_restart_abort();
      int n_rv = 0, n_we = 0;
      bit seen = 0;
      cpu_req = 0;
      start_burst(1'b0, 16'h0200, 8'd5);
      tick(); tick();
      if (o_dma_rv === 1'b1) n_rv++;
      dma_start = 1; dma_we = 1; dma_base = 16'h0600; dma_len = 8'd1; dma_wvalid = 1;
      tick();
      dma_start = 0; dma_wvalid = 0;
      if (o_dma_rv === 1'b1) n_rv++;
      n_assert++; if (o_addr !== 16'h0202 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL rs_ignored: got addr %h we %b want 0202 0", o_addr, o_mem_we); end
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (o_dma_rv === 1'b1) n_rv++;
         if (o_mem_we === 1'b1) n_we++;
         if (o_done === 1'b1) seen = 1;
      end
      n_assert++; if (!seen || n_rv != 5 || n_we != 0) begin n_fail++; $display("FAIL rs_beats: got done %b rvalids %0d writes %0d want 1 5 0", seen, n_rv, n_we); end
      // Abort a read burst mid-flight.
      start_burst(1'b0, 16'h0300, 8'd6);
      tick(); tick(); tick();
      reset = 1; tick();
      reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
      tick();
      n_assert++; if (o_busy !== 1'b0 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL ab_state: got busy %b we %b want 0 0", o_busy, o_mem_we); end
      n_assert++; if (o_dma_rv !== 1'b0) begin n_fail++; $display("FAIL ab_rvalid: got %b want 0", o_dma_rv); end
      for (int i = 0; i < 6; i++) begin
         n_assert++; if (o_cpu_rdy !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL ab_cpu %0d: got rdy %b done %b want 1 0", i, o_cpu_rdy, o_done); end
         tick();
      end
      cpu_req = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 399) == 0);
         cpu_req    = ($urandom_range(0, 99) < 60);
         cpu_we     = $urandom_range(0, 1);
         cpu_addr   = 16'($urandom_range(0, 63));
         cpu_wdata  = 8'($urandom);
         dma_start  = ($urandom_range(0, 11) == 0);
         dma_we     = $urandom_range(0, 1);
         dma_base   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom_range(0, 63));
         dma_len    = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
         dma_wdata  = 8'($urandom);
         dma_wvalid = ($urandom_range(0, 99) < 70);
         tick();
         n_assert++; if (o_cpu_rdy !== e_cpu_rdy) begin n_fail++; $display("FAIL rnd_cpu_rdy c%0d: got %b want %b", i, o_cpu_rdy, e_cpu_rdy); end
         n_assert++; if (o_wready !== e_wready)   begin n_fail++; $display("FAIL rnd_wready c%0d: got %b want %b", i, o_wready, e_wready); end
         n_assert++; if (o_mem_we !== e_mem_we)   begin n_fail++; $display("FAIL rnd_mem_we c%0d: got %b want %b", i, o_mem_we, e_mem_we); end
         n_assert++; if (o_addr !== e_addr)       begin n_fail++; $display("FAIL rnd_mem_addr c%0d: got %h want %h", i, o_addr, e_addr); end
         if (e_mem_we) begin
            n_assert++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_mem_wdata c%0d: got %h want %h", i, o_wdata, e_wdata); end
         end
         n_assert++; if (o_cpu_rv !== e_cpu_rv) begin n_fail++; $display("FAIL rnd_cpu_rvalid c%0d: got %b want %b", i, o_cpu_rv, e_cpu_rv); end
         n_assert++; if (o_dma_rv !== e_dma_rv) begin n_fail++; $display("FAIL rnd_dma_rvalid c%0d: got %b want %b", i, o_dma_rv, e_dma_rv); end
         if (e_cpu_rv) begin
            n_assert++; if (o_cpu_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", i, o_cpu_rdata, e_rdata); end
         end
         if (e_dma_rv) begin
            n_assert++; if (o_dma_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_dma_rdata c%0d: got %h want %h", i, o_dma_rdata, e_rdata); end
         end
         n_assert++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", i, o_busy, e_busy); end
         n_assert++; if (o_done !== e_done) begin n_fail++; $display("FAIL rnd_done c%0d: got %b want %b", i, o_done, e_done); end
      end
      reset = 0; dma_start = 0; cpu_req = 0; dma_wvalid = 0;
   endtask

   initial begin
      reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_start = 0; dma_we = 0; dma_base = '0; dma_len = '0; dma_wdata = '0; dma_wvalid = 0;
      m_active = 0; m_dir = 0; m_ptr = 0; m_left = 0; m_streak = 0;
      m_cpu_rv = 0; m_dma_rv = 0; m_done = 0; m_rdata = '0;
      for (int a = 0; a < 65536; a++) begin
         logic [7:0] v;
         v = 8'($urandom);
         ram[a] = v;
         exp_mem[a] = v;
      end
      test_reset();
      test_uncontended_write();
      test_contended_read();
      test_write_stall();
      test_wrap_and_len0();
      test_restart_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory arbiter between the 6502 core and a DMA/debug port. It sits between `top`'s CPU bus and the `mem` block (ROM/RAM). A bench or loader can use it to burst-load RAM or read it back while the CPU runs. The CPU gets every cycle the DMA does not use, and the DMA is capped at `BURST` consecutive beats while the CPU is waiting.

## Interface
- `ADDR_W`, 16, address width for the CPU, DMA and memory sides.
- `DATA_W`, 8, data width.
- `BURST`, 4, maximum consecutive DMA beats while `cpu_req` is high (≥1).

- `ph1` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU requests an access this cycle.
- `cpu_we` in 1: CPU access is a write.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_rdy` out 1: CPU access is granted this cycle. When low, the CPU holds its request (stall).
- `cpu_rdata` out DATA_W: CPU read data; equals `mem_rdata`.
- `cpu_rvalid` out 1: high the cycle after a granted CPU read.
- `dma_start` in 1: one-cycle pulse that starts a burst.
- `dma_we` in 1: burst direction, 1 = write. Sampled with `dma_start`.
- `dma_base` in ADDR_W: burst start address. Sampled with `dma_start`.
- `dma_len` in 8: beat count. 0 means 256. Sampled with `dma_start`.
- `dma_wdata` in DATA_W: write beat data.
- `dma_wvalid` in 1: `dma_wdata` is valid.
- `dma_wready` out 1: a write beat is consumed this cycle.
- `dma_rdata` out DATA_W: read beat data.
- `dma_rvalid` out 1: read beat data is valid.
- `dma_busy` out 1: a burst is in progress.
- `dma_done` out 1: one-cycle pulse when a burst completes.
- `mem_addr` out ADDR_W: memory address.
- `mem_we` out 1: memory write enable.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data; synchronous read, valid the cycle after the address.

## Operation
- Registered state:
  - `active`: burst in progress.
  - `dir`: burst direction.
  - `ptr`: ADDR_W address counter.
  - `remain`: 9-bit beats left.
  - `run`: consecutive DMA beats, 0..BURST.
  - `cpu_rd_d`, `dma_rd_d`, `last_d`: one-cycle delayed flags.
- Start:
  - Accepted only when `dma_start` is high and `active` is 0. It loads `ptr=dma_base`, `remain = (dma_len==0) ? 256 : dma_len`, `dir=dma_we`, `run=0`, `active=1`.
  - `dma_start` while `active` is 1 is ignored, with no side effects.
- A DMA beat is eligible when:
  - `active` is 1,
  - and `run<BURST` or `cpu_req`=0,
  - and, for a write burst, `dma_wvalid`=1.
- Slot grant, evaluated each cycle:
  - **DMA beat eligible:** the memory port is driven from `ptr`. For writes, `mem_we=1`, `mem_wdata=dma_wdata` and `dma_wready=1`. Then `ptr` increments (wraps 0xFFFF→0x0000), `remain` decrements, and `run` increments (saturating at BURST). `cpu_rdy`=0.
  - **Otherwise, `cpu_req` high:** the port is driven from the CPU. `mem_we=cpu_we`, `cpu_rdy`=1, and `run` clears to 0.
  - **Neither:** the port is idle. `mem_we`=0, and `mem_addr`/`mem_wdata` hold the CPU inputs.
- A write burst stalled on `dma_wvalid`=0 gives the slot to the CPU and does not advance.
- The final beat (`remain==1`) clears `active` at the edge and sets `last_d`.
- `dma_done`=`last_d`: one cycle after the final beat, coincident with the final `dma_rvalid` for read bursts.
- `dma_busy`=`active`.
- Reset mid-burst aborts: `active`=0, no `dma_done`, and a pending `rvalid` is dropped.

## Timing
- Reset values: `cpu_rdy`, `cpu_rvalid`, `dma_wready`, `dma_rvalid`, `dma_busy`, `dma_done` and `mem_we` are all 0. `ptr` and `remain` are 0, so `mem_addr` shows `cpu_addr`.
- `cpu_rdy`, `dma_wready`, `mem_*` are combinational from registered state plus the current request inputs. There are no paths from `mem_rdata` to the `mem_*` outputs.
- A read granted in cycle N produces `*_rvalid`=1 with `*_rdata`=`mem_rdata` in cycle N+1.
- Burst start latency: `dma_start` at cycle N allows the first beat at N+1 at the earliest. `dma_busy` is high from N+1.
- Uncontended burst of L beats: beats occupy N+1..N+L, `dma_done` at N+L+1, and `dma_busy` falls at N+L+1.
- Under constant `cpu_req`, the slot pattern is BURST DMA beats, then 1 CPU slot, repeating.
- `cpu_req` rising while `run<BURST` waits until `run` reaches BURST.

## Test plan
- **Uncontended write burst:** reset; `dma_start` with we=1, base=0x0040, len=3, `wvalid` held high with data 0x33,0x34,0x35. Required:
  - RAM[0x40..0x42] = 33/34/35;
  - `dma_done` exactly 4 cycles after start;
  - `cpu_rdy` stays 0 throughout.
- **Contended read burst:** `cpu_req`=1 throughout (reads at 0xF000); DMA read with base=0x0040, len=10, BURST=4. Required:
  - slot sequence DDDD C DDDD C DD;
  - `cpu_rvalid` follows each C by 1 cycle;
  - 10 `dma_rvalid` pulses;
  - `dma_done` with the 10th.
- **Write stall:** write burst with len=2 and `wvalid`=0 for 3 cycles. Required:
  - no `mem_we`, `ptr` unchanged;
  - waiting `cpu_req` gets `cpu_rdy`;
  - burst completes after `wvalid` rises.
- **Wrap and len=0:**
  - base=0xFFFE, len=2: `mem_addr` goes 0xFFFE then 0xFFFF.
  - base=0xFFFF, len=2: addresses 0xFFFF, 0x0000.
  - len=0: exactly 256 beats, then `dma_done`.
- **Restart/abort:**
  - `dma_start` while busy is ignored (beat count unchanged).
  - `reset` mid-burst: next cycle `dma_busy`=0 and `mem_we`=0, with no `dma_done`; the CPU regains every slot.
